// File: rtl/tao_step_ctrl.sv
// tao_step_ctrl: fetch/step sequencer for the single-cycle TAO core.
// Define TAO_HALT_EBREAK_EN to build the ebreak halt state.
module tao_step_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] core_inst,
    output logic        core_step,
    input  logic [31:0] core_dnpc,
    output logic [31:0] pc,
    input  logic        stall,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retire_cnt
);

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
`ifdef TAO_HALT_EBREAK_EN
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
`endif

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_STALL = 3'd4,
`ifdef TAO_HALT_EBREAK_EN
        ST_HALT  = 3'd5,
`endif
        ST_FAULT = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retire_q, retire_d;
    logic [7:0]  tmo_q, tmo_d;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        retire_d       = retire_q;
        tmo_d          = tmo_q;
        imem_req_valid = 1'b0;
        imem_rsp_ready = 1'b0;
        core_step      = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_REQ;
            ST_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_WAIT: begin
                imem_rsp_ready = 1'b1;
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = ST_FAULT;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = ST_EXEC;
                    end
                end else if (tmo_q == TIMEOUT_CNT) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_EXEC: begin
                core_step = 1'b1;
`ifdef TAO_HALT_EBREAK_EN
                // ebreak retires but keeps pc pointing at itself for the debugger
                if (inst_q == EBREAK_INST) begin
                    retire_d = retire_q + 32'd1;
                    state_d  = ST_HALT;
                end else
`endif
                if (core_dnpc[1:0] != 2'b00) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d     = core_dnpc;
                    retire_d = retire_q + 32'd1;
                    state_d  = stall ? ST_STALL : ST_REQ;
                end
            end
            ST_STALL: begin
                if (!stall) state_d = ST_REQ;
            end
`ifdef TAO_HALT_EBREAK_EN
            ST_HALT:  state_d = ST_HALT;
`endif
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RESET;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            retire_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            retire_q <= retire_d;
            tmo_q    <= tmo_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign pc            = pc_q;
    assign core_inst     = inst_q;
    assign retire_cnt    = retire_q;
    assign fault         = (state_q == ST_FAULT);
`ifdef TAO_HALT_EBREAK_EN
    assign halted        = (state_q == ST_HALT);
`else
    assign halted        = 1'b0;
`endif

endmodule

// File: tb/tb_tao_step_ctrl.sv
// tb_tao_step_ctrl: scoreboard bench for tao_step_ctrl with a behavioural
// instruction memory and next-PC model; DUT built with TIMEOUT=10.
module tb_tao_step_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] core_inst;
    logic        core_step;
    logic [31:0] core_dnpc;
    logic [31:0] pc;
    logic        stall = 1'b0;
    logic        halted, fault;
    logic [31:0] retire_cnt;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;

    // memory / next-pc model knobs
    int          ready_lo    = 0;
    int          rsp_delay   = 0;
    bit          mem_silent  = 1'b0;
    bit          rsp_err     = 1'b0;
    bit          bad_dnpc    = 1'b0;
    logic [31:0] ebreak_addr = 32'hFFFF_FFFC;

    tao_step_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .core_inst(core_inst), .core_step(core_step), .core_dnpc(core_dnpc),
        .pc(pc), .stall(stall), .halted(halted), .fault(fault),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_for(input logic [31:0] a);
        if (a == ebreak_addr) return 32'h0010_0073;
        return {a[11:0], 20'h00013};
    endfunction

    // Memory model: handshakes are inferred from values held across the last rising edge.
    initial begin : mem_model
        bit          pending = 1'b0;
        int          wait_left = 0;
        logic [31:0] pend_addr = '0;
        bit          prev_req_valid = 1'b0;
        bit          prev_rsp_ready = 1'b0;
        logic [31:0] prev_req_addr = '0;
        sb_t         e;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        core_dnpc      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending        = 1'b0;
                imem_rsp_valid = 1'b0;
                imem_rsp_err   = 1'b0;
            end else begin
                if (imem_rsp_valid && prev_rsp_ready) imem_rsp_valid = 1'b0;
                if (prev_req_valid && imem_req_ready) begin
                    pending   = 1'b1;
                    wait_left = rsp_delay;
                    pend_addr = prev_req_addr;
                end
                if (pending && !mem_silent) begin
                    if (wait_left == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = inst_for(pend_addr);
                        imem_rsp_err   = rsp_err;
                        pending        = 1'b0;
                        if (!rsp_err) begin
                            e.addr = pend_addr;
                            e.data = imem_rsp_data;
                            sb_q.push_back(e);
                        end
                    end else begin
                        wait_left--;
                    end
                end
            end
            if (imem_req_valid && ready_lo > 0) begin
                imem_req_ready = 1'b0;
                ready_lo--;
            end else begin
                imem_req_ready = 1'b1;
            end
            core_dnpc      = bad_dnpc ? 32'h8000_0102 : pc + 32'd4;
            prev_req_valid = imem_req_valid;
            prev_req_addr  = imem_req_addr;
            prev_rsp_ready = imem_rsp_ready;
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sb_q.delete();
        ready_lo   = 0;
        rsp_delay  = 0;
        mem_silent = 1'b0;
        rsp_err    = 1'b0;
        bad_dnpc   = 1'b0;
        stall      = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_req_valid got %b want 0", imem_req_valid); end
        vec_cnt++; if (imem_rsp_ready !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_rsp_ready got %b want 0", imem_rsp_ready); end
        vec_cnt++; if (core_step !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_core_step got %b want 0", core_step); end
        vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
        vec_cnt++; if (fault !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_fault got %b want 0", fault); end
        vec_cnt++; if (pc !== RST_PC) begin err_cnt++; $display("[TB] FAIL reset_pc got %h want %h", pc, RST_PC); end
        vec_cnt++; if (core_inst !== 32'h0000_0013) begin err_cnt++; $display("[TB] FAIL reset_core_inst got %h want 00000013", core_inst); end
        vec_cnt++; if (retire_cnt !== 32'd0) begin err_cnt++; $display("[TB] FAIL reset_retire got %0d want 0", retire_cnt); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr = RST_PC;
        int steps = 0;
        sb_t e;
        hold_reset();
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                vec_cnt++; if (imem_req_addr !== exp_addr) begin err_cnt++; $display("[TB] FAIL zw_req_addr cyc %0d got %h want %h", c, imem_req_addr, exp_addr); end
            end
            if (core_step) begin
                steps++;
                vec_cnt++; if (c % 3 != 0) begin err_cnt++; $display("[TB] FAIL zw_step_cadence step at cyc %0d want multiple of 3", c); end
                vec_cnt++;
                if (sb_q.size() == 0) begin
                    err_cnt++; $display("[TB] FAIL zw_sb_empty step at cyc %0d with no expected fetch", c);
                end else begin
                    e = sb_q.pop_front();
                    if (core_inst !== e.data || pc !== e.addr) begin err_cnt++; $display("[TB] FAIL zw_step got inst %h pc %h want inst %h pc %h", core_inst, pc, e.data, e.addr); end
                end
                exp_addr += 32'd4;
            end
        end
        vec_cnt++; if (steps != 3) begin err_cnt++; $display("[TB] FAIL zw_step_count got %0d want 3", steps); end
        vec_cnt++; if (retire_cnt !== 32'd3) begin err_cnt++; $display("[TB] FAIL zw_retire got %0d want 3", retire_cnt); end
    endtask

    task automatic test_wait_states();
        int steps = 0;
        sb_t e;
        hold_reset();
        ready_lo  = 4;
        rsp_delay = 5;
        rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            vec_cnt++; if (imem_req_valid !== (c <= 5 || c == 13)) begin err_cnt++; $display("[TB] FAIL ws_req_valid cyc %0d got %b", c, imem_req_valid); end
            if (c <= 5) begin
                vec_cnt++; if (imem_req_addr !== RST_PC) begin err_cnt++; $display("[TB] FAIL ws_addr_stable cyc %0d got %h want %h", c, imem_req_addr, RST_PC); end
            end
            if (core_step) begin
                steps++;
                vec_cnt++; if (c != 12) begin err_cnt++; $display("[TB] FAIL ws_step_cycle got cyc %0d want 12", c); end
                vec_cnt++;
                if (sb_q.size() == 0) begin
                    err_cnt++; $display("[TB] FAIL ws_sb_empty step with no expected fetch");
                end else begin
                    e = sb_q.pop_front();
                    if (core_inst !== e.data || pc !== e.addr) begin err_cnt++; $display("[TB] FAIL ws_step got inst %h pc %h want inst %h pc %h", core_inst, pc, e.data, e.addr); end
                end
            end
        end
        vec_cnt++; if (steps != 1) begin err_cnt++; $display("[TB] FAIL ws_step_count got %0d want 1", steps); end
        vec_cnt++; if (fault !== 1'b0) begin err_cnt++; $display("[TB] FAIL ws_fault got %b want 0", fault); end
    endtask

    task automatic test_timeout();
        hold_reset();
        mem_silent = 1'b1;
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            vec_cnt++; if (fault !== (c >= 13)) begin err_cnt++; $display("[TB] FAIL to_fault cyc %0d got %b want %b", c, fault, c >= 13); end
            vec_cnt++; if (imem_req_valid !== (c == 1)) begin err_cnt++; $display("[TB] FAIL to_req_valid cyc %0d got %b", c, imem_req_valid); end
            vec_cnt++; if (imem_rsp_ready !== (c >= 2 && c <= 12)) begin err_cnt++; $display("[TB] FAIL to_rsp_ready cyc %0d got %b", c, imem_rsp_ready); end
        end
    endtask

    task automatic test_bus_error();
        hold_reset();
        rsp_err = 1'b1;
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vec_cnt++; if (core_step !== 1'b0) begin err_cnt++; $display("[TB] FAIL err_step cyc %0d got %b want 0", c, core_step); end
            if (c >= 3) begin
                vec_cnt++; if (fault !== 1'b1 || imem_req_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL err_fault cyc %0d got fault %b req %b want 1 0", c, fault, imem_req_valid); end
            end
        end
    endtask

    task automatic test_misaligned();
        sb_t e;
        hold_reset();
        bad_dnpc = 1'b1;
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 3) begin
                vec_cnt++;
                if (core_step !== 1'b1 || sb_q.size() == 0) begin
                    err_cnt++; $display("[TB] FAIL mis_step got step %b queued %0d want 1 1", core_step, sb_q.size());
                end else begin
                    e = sb_q.pop_front();
                    if (core_inst !== e.data) begin err_cnt++; $display("[TB] FAIL mis_inst got %h want %h", core_inst, e.data); end
                end
            end
            if (c == 4) begin
                vec_cnt++; if (fault !== 1'b1) begin err_cnt++; $display("[TB] FAIL mis_fault got %b want 1", fault); end
                vec_cnt++; if (pc !== RST_PC) begin err_cnt++; $display("[TB] FAIL mis_pc got %h want %h", pc, RST_PC); end
                vec_cnt++; if (retire_cnt !== 32'd0) begin err_cnt++; $display("[TB] FAIL mis_retire got %0d want 0", retire_cnt); end
            end
            if (c >= 4) begin
                vec_cnt++; if (imem_req_valid !== 1'b0 || core_step !== 1'b0) begin err_cnt++; $display("[TB] FAIL mis_quiet cyc %0d got req %b step %b", c, imem_req_valid, core_step); end
            end
        end
    endtask

    task automatic test_stall();
        sb_t e;
        hold_reset();
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) stall = 1'b1;
            if (c == 8) stall = 1'b0;
            vec_cnt++; if (imem_req_valid !== (c == 1 || c == 9)) begin err_cnt++; $display("[TB] FAIL st_req_valid cyc %0d got %b", c, imem_req_valid); end
            if (c == 3) begin
                vec_cnt++;
                if (core_step !== 1'b1 || sb_q.size() == 0) begin
                    err_cnt++; $display("[TB] FAIL st_step got step %b queued %0d want 1 1", core_step, sb_q.size());
                end else begin
                    e = sb_q.pop_front();
                    if (core_inst !== e.data || pc !== e.addr) begin err_cnt++; $display("[TB] FAIL st_step got inst %h pc %h want inst %h pc %h", core_inst, pc, e.data, e.addr); end
                end
            end
            if (c == 5) begin
                vec_cnt++; if (retire_cnt !== 32'd1 || pc !== RST_PC + 32'd4) begin err_cnt++; $display("[TB] FAIL st_retire got cnt %0d pc %h want 1 %h", retire_cnt, pc, RST_PC + 32'd4); end
            end
            if (c == 9) begin
                vec_cnt++; if (imem_req_addr !== RST_PC + 32'd4) begin err_cnt++; $display("[TB] FAIL st_resume_addr got %h want %h", imem_req_addr, RST_PC + 32'd4); end
            end
        end
    endtask

    task automatic test_ebreak();
        sb_t e;
        hold_reset();
        ebreak_addr = RST_PC + 32'd4;
        rst = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 3 || c == 6) begin
                vec_cnt++;
                if (core_step !== 1'b1 || sb_q.size() == 0) begin
                    err_cnt++; $display("[TB] FAIL eb_step cyc %0d got step %b queued %0d", c, core_step, sb_q.size());
                end else begin
                    e = sb_q.pop_front();
                    if (core_inst !== e.data || pc !== e.addr) begin err_cnt++; $display("[TB] FAIL eb_step got inst %h pc %h want inst %h pc %h", core_inst, pc, e.data, e.addr); end
                end
            end
            if (c == 7) begin
                vec_cnt++; if (retire_cnt !== 32'd2) begin err_cnt++; $display("[TB] FAIL eb_retire got %0d want 2", retire_cnt); end
`ifdef TAO_HALT_EBREAK_EN
                vec_cnt++; if (halted !== 1'b1) begin err_cnt++; $display("[TB] FAIL eb_halted got %b want 1", halted); end
                vec_cnt++; if (pc !== RST_PC + 32'd4) begin err_cnt++; $display("[TB] FAIL eb_pc got %h want %h", pc, RST_PC + 32'd4); end
`else
                vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("[TB] FAIL eb_halted got %b want 0", halted); end
                vec_cnt++; if (pc !== RST_PC + 32'd8) begin err_cnt++; $display("[TB] FAIL eb_pc got %h want %h", pc, RST_PC + 32'd8); end
`endif
            end
`ifdef TAO_HALT_EBREAK_EN
            if (c >= 7) begin
                vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL eb_no_req cyc %0d got %b want 0", c, imem_req_valid); end
            end
`endif
        end
        hold_reset();
        ebreak_addr = 32'hFFFF_FFFC;
        vec_cnt++; if (pc !== RST_PC || halted !== 1'b0) begin err_cnt++; $display("[TB] FAIL eb_reset got pc %h halted %b want %h 0", pc, halted, RST_PC); end
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin err_cnt++; $display("[TB] FAIL eb_resume got req %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RST_PC); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_bus_error();
        test_misaligned();
        test_stall();
        test_ebreak();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
